// File: rtl/formant_pkg.sv
// Shared types and arithmetic for the formant segmentation DP column scheduler.
package formant_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int BRAM_LAT  = 2;
  localparam logic [BIT_WIDTH-1:0] COST_MAX = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW_INIT = 3'd1,
    SCAN     = 3'd2,
    DRAIN    = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } dp_state_t;

  // Unsigned add clamped at COST_MAX; an all-ones operand therefore stays infeasible.
  function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
    logic [BIT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIT_WIDTH] ? COST_MAX : s[BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/min_argmin_acc.sv
// Registered running minimum with argmin; strict less-than keeps the earliest tag on ties.
module min_argmin_acc #(
  parameter int W  = 32,
  parameter int TW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic [TW-1:0] init_tag_i,
  input  logic          valid_i,
  input  logic [W-1:0]  cost_i,
  input  logic [TW-1:0] tag_i,
  output logic [W-1:0]  min_o,
  output logic [TW-1:0] arg_o
);

  logic [W-1:0]  min_q, min_d;
  logic [TW-1:0] arg_q, arg_d;

  always_comb begin
    min_d = min_q;
    arg_d = arg_q;
    if (clear_i) begin
      min_d = '1;
      arg_d = init_tag_i;
    end else if (valid_i && (cost_i < min_q)) begin
      min_d = cost_i;
      arg_d = tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q <= '0;
      arg_q <= '0;
    end else begin
      min_q <= min_d;
      arg_q <= arg_d;
    end
  end

  assign min_o = min_q;
  assign arg_o = arg_q;

endmodule

// File: rtl/formant_dp_sched.sv
// Column sequencer for the formant DP: per row k, scans boundaries j through the E/F read ports
// and writes F_k[i]/B_k[i]. Read ports: address in cycle t, data valid in cycle t+BRAM_LAT.
module formant_dp_sched
  import formant_pkg::*;
#(
  parameter int I        = 160,
  parameter int FORMANTS = 4,
  localparam int AW = $clog2(I),
  localparam int KW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 begin_iter,
  input  logic [AW-1:0]        i,
  output logic [AW-1:0]        e_rd_addr,
  input  logic [BIT_WIDTH-1:0] e_rd_data,
  output logic [KW-1:0]        f_rd_row,
  output logic [AW-1:0]        f_rd_addr,
  input  logic [BIT_WIDTH-1:0] f_rd_data,
  output logic [KW-1:0]        wr_row,
  output logic [BIT_WIDTH-1:0] f_wr_data,
  output logic [AW-1:0]        b_wr_data,
  output logic                 wr_valid,
  output logic                 busy,
  output logic                 iter_done,
  output logic [2:0]           dbg_state
);

  localparam int JW = AW + 1;
  localparam int DW = $clog2(BRAM_LAT + 2) + 1;

  dp_state_t            state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [JW-1:0]        j_q, j_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [BRAM_LAT:0]    vld_q;
  logic [AW-1:0]        tag_q [BRAM_LAT+1];
  logic [BIT_WIDTH-1:0] sum_q;
  logic [BIT_WIDTH-1:0] min_cost;
  logic [AW-1:0]        min_arg;

  logic          row0, feasible, issue, last_row;
  logic [JW-1:0] k_ext, i_ext, j_first, j_last;

  assign row0     = (k_q == '0);
  assign k_ext    = JW'(k_q);
  assign i_ext    = JW'(i);
  assign feasible = row0 || (i_ext >= k_ext);
  assign j_first  = row0 ? '0 : (k_ext - JW'(1));
  assign j_last   = i_ext - JW'(1);
  assign issue    = (state_q == SCAN);
  assign last_row = (k_q == KW'(FORMANTS - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (begin_iter) begin
          state_d = ROW_INIT;
          k_d     = '0;
        end
      end
      ROW_INIT: begin
        j_d     = j_first;
        drain_d = '0;
        state_d = feasible ? SCAN : WRITE;
      end
      SCAN: begin
        // Row 0 has a single candidate (E[0]); other rows stop once j = i-1 is issued.
        if (row0 || (j_q == j_last)) state_d = DRAIN;
        else                         j_d     = j_q + JW'(1);
      end
      DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(BRAM_LAT + 1)) state_d = WRITE;
      end
      WRITE: begin
        if (last_row) state_d = DONE;
        else begin
          k_d     = k_q + KW'(1);
          state_d = ROW_INIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid/j tags travel with the read data; the last stage lines up with sum_q.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      k_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      vld_q   <= '0;
      sum_q   <= '0;
      for (int s = 0; s <= BRAM_LAT; s++) tag_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      vld_q    <= {vld_q[BRAM_LAT-1:0], issue};
      tag_q[0] <= j_q[AW-1:0];
      for (int s = 1; s <= BRAM_LAT; s++) tag_q[s] <= tag_q[s-1];
      sum_q    <= sat_add(row0 ? '0 : f_rd_data, e_rd_data);
    end
  end

  min_argmin_acc #(
    .W  (BIT_WIDTH),
    .TW (AW)
  ) u_acc (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .clear_i    (state_q == ROW_INIT),
    .init_tag_i (feasible ? j_first[AW-1:0] : '0),
    .valid_i    (vld_q[BRAM_LAT]),
    .cost_i     (sum_q),
    .tag_i      (tag_q[BRAM_LAT]),
    .min_o      (min_cost),
    .arg_o      (min_arg)
  );

  assign e_rd_addr = issue ? (row0 ? '0 : (j_q[AW-1:0] + AW'(1))) : '0;
  assign f_rd_row  = (issue && !row0) ? (k_q - KW'(1)) : '0;
  assign f_rd_addr = (issue && !row0) ? j_q[AW-1:0] : '0;
  assign wr_valid  = (state_q == WRITE);
  assign wr_row    = wr_valid ? k_q : '0;
  assign f_wr_data = wr_valid ? min_cost : '0;
  assign b_wr_data = wr_valid ? min_arg : '0;
  assign iter_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_formant_dp_sched.sv
// Directed bench for formant_dp_sched with I=8, FORMANTS=3 and 2-cycle E/F read models.
module tb_formant_dp_sched;
  import formant_pkg::*;

  localparam int NI = 8;
  localparam int NF = 3;

  logic        clk, rst_in, begin_iter;
  logic [2:0]  i;
  logic [2:0]  e_rd_addr, f_rd_addr, b_wr_data;
  logic [1:0]  f_rd_row, wr_row;
  logic [31:0] e_rd_data, f_rd_data, f_wr_data;
  logic        wr_valid, busy, iter_done;
  logic [2:0]  dbg_state;

  logic [31:0] emem [NI];
  logic [31:0] fmem [NF][NI];
  logic [31:0] e_d1, f_d1;

  logic [36:0] got_q[$];
  logic [36:0] exp_q[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          errors   = 0;
  int          checks   = 0;
  int          rd_ptr   = 0;

  formant_dp_sched #(.I(NI), .FORMANTS(NF)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .begin_iter (begin_iter),
    .i          (i),
    .e_rd_addr  (e_rd_addr),
    .e_rd_data  (e_rd_data),
    .f_rd_row   (f_rd_row),
    .f_rd_addr  (f_rd_addr),
    .f_rd_data  (f_rd_data),
    .wr_row     (wr_row),
    .f_wr_data  (f_wr_data),
    .b_wr_data  (b_wr_data),
    .wr_valid   (wr_valid),
    .busy       (busy),
    .iter_done  (iter_done),
    .dbg_state  (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: two register stages between address and data
  always @(posedge clk) begin
    e_d1      <= emem[e_rd_addr];
    e_rd_data <= e_d1;
    f_d1      <= (f_rd_row < 2'd3) ? fmem[f_rd_row][f_rd_addr] : 32'h0;
    f_rd_data <= f_d1;
  end

  // write/done/busy monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_valid)  got_q.push_back({wr_row, f_wr_data, b_wr_data});
    if (iter_done) done_cnt++;
    if (busy)      busy_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [36:0] wr(input logic [1:0] r, input logic [31:0] f, input logic [2:0] b);
    return {r, f, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mems();
    for (int a = 0; a < NI; a++) begin
      emem[a] = 32'h0;
      for (int r = 0; r < NF; r++) fmem[r][a] = 32'h0;
    end
  endtask

  // Compare writes captured since wr_base against exp_q, in order.
  task automatic check_writes(input string tag, input int wr_base);
    int n;
    n = got_q.size() - wr_base;
    chk($sformatf("%s_nwr", tag), 64'(n), 64'(exp_q.size()));
    rd_ptr = wr_base;
    for (int w = 0; exp_q.size() > 0; w++) begin
      logic [36:0] e;
      e = exp_q.pop_front();
      if (rd_ptr < got_q.size()) chk($sformatf("%s_wr%0d", tag, w), 64'(got_q[rd_ptr]), 64'(e));
      else                       chk($sformatf("%s_wr%0d_missing", tag, w), 64'h1, 64'h0);
      rd_ptr++;
    end
  endtask

  task automatic run_col(input string tag, input int col, input bit repulse, input int n_busy);
    int wr_base, d_base, b_base;
    wr_base    = got_q.size();
    d_base     = done_cnt;
    b_base     = busy_cnt;
    i          = 3'(col);
    begin_iter = 1'b1;
    @(negedge clk);
    begin_iter = 1'b0;
    if (repulse) begin
      repeat (3) @(negedge clk);
      begin_iter = 1'b1;
      @(negedge clk);
      begin_iter = 1'b0;
    end
    for (int n = 0; n < 300 && done_cnt == d_base; n++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk($sformatf("%s_done", tag), 64'(done_cnt - d_base), 64'd1);
    chk($sformatf("%s_busy", tag), 64'(busy_cnt - b_base), 64'(n_busy));
    check_writes(tag, wr_base);
  endtask

  task automatic load_t2();
    clear_mems();
    emem[0] = 32'd9; emem[1] = 32'd4; emem[2] = 32'd6; emem[3] = 32'd2;
    fmem[0][0] = 32'd1; fmem[0][1] = 32'd3; fmem[0][2] = 32'd7;
    fmem[1][1] = 32'd10; fmem[1][2] = 32'd2;
  endtask

  initial begin
    int wr_base, d_base;
    rst_in     = 1'b1;
    begin_iter = 1'b0;
    i          = 3'd0;
    clear_mems();
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_wr_valid",  64'(wr_valid),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_iter_done", 64'(iter_done), 64'd0);
    chk("rst_e_addr",    64'(e_rd_addr), 64'd0);
    chk("rst_f_addr",    64'(f_rd_addr), 64'd0);
    chk("rst_f_wr_data", 64'(f_wr_data), 64'd0);
    chk("rst_state",     64'(dbg_state), 64'(IDLE));
    rst_in = 1'b0;
    repeat (2) @(negedge clk);

    // 1: i=0, only row 0 feasible
    emem[0] = 32'd5;
    exp_q.push_back(wr(2'd0, 32'd5, 3'd0));
    exp_q.push_back(wr(2'd1, 32'hFFFF_FFFF, 3'd0));
    exp_q.push_back(wr(2'd2, 32'hFFFF_FFFF, 3'd0));
    run_col("t1_i0", 0, 1'b0, 12);

    // 2: i=3, row1 min at j=0, row2 min at j=2
    load_t2();
    exp_q.push_back(wr(2'd0, 32'd9, 3'd0));
    exp_q.push_back(wr(2'd1, 32'd5, 3'd0));
    exp_q.push_back(wr(2'd2, 32'd4, 3'd2));
    run_col("t2_i3", 3, 1'b0, 25);

    // 3: tie on row 1 resolves to smallest j
    clear_mems();
    emem[0] = 32'd7; emem[1] = 32'd3; emem[2] = 32'd4;
    fmem[0][0] = 32'd2; fmem[0][1] = 32'd1;
    fmem[1][1] = 32'd0;
    exp_q.push_back(wr(2'd0, 32'd7, 3'd0));
    exp_q.push_back(wr(2'd1, 32'd5, 3'd0));
    exp_q.push_back(wr(2'd2, 32'd4, 3'd1));
    run_col("t3_tie", 2, 1'b0, 23);

    // 4: saturation on row 1, all-equal candidates on row 2
    for (int a = 0; a < NI; a++) begin
      emem[a]    = 32'h20;
      fmem[0][a] = 32'hFFFF_FFF0;
      fmem[1][a] = 32'h10;
    end
    exp_q.push_back(wr(2'd0, 32'h20, 3'd0));
    exp_q.push_back(wr(2'd1, 32'hFFFF_FFFF, 3'd0));
    exp_q.push_back(wr(2'd2, 32'h30, 3'd1));
    run_col("t4_sat", 4, 1'b0, 27);

    // 5: begin_iter re-pulsed while busy
    load_t2();
    exp_q.push_back(wr(2'd0, 32'd9, 3'd0));
    exp_q.push_back(wr(2'd1, 32'd5, 3'd0));
    exp_q.push_back(wr(2'd2, 32'd4, 3'd2));
    run_col("t5_repulse", 3, 1'b1, 25);

    // 6: reset mid-SCAN of row 1 at i=7, then a clean full-length column
    clear_mems();
    for (int a = 0; a < NI; a++) emem[a] = 32'(a + 1);
    fmem[0][0] = 32'd10; fmem[0][1] = 32'd8; fmem[0][2] = 32'd6; fmem[0][3] = 32'd4;
    fmem[0][4] = 32'd2;  fmem[0][5] = 32'd1; fmem[0][6] = 32'd3;
    fmem[1][1] = 32'd20; fmem[1][2] = 32'd15; fmem[1][3] = 32'd9;
    fmem[1][4] = 32'd5;  fmem[1][5] = 32'd3;  fmem[1][6] = 32'd0;
    wr_base    = got_q.size();
    d_base     = done_cnt;
    i          = 3'd7;
    begin_iter = 1'b1;
    @(negedge clk);
    begin_iter = 1'b0;
    for (int n = 0; n < 100 && !wr_valid; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_in_scan", 64'(dbg_state), 64'(SCAN));
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk("t6_abort_wr_valid",  64'(wr_valid),  64'd0);
    chk("t6_abort_iter_done", 64'(iter_done), 64'd0);
    chk("t6_abort_busy",      64'(busy),      64'd0);
    repeat (30) @(negedge clk);
    chk("t6_abort_nodone", 64'(done_cnt - d_base), 64'd0);
    exp_q.push_back(wr(2'd0, 32'd1, 3'd0));
    check_writes("t6_abort", wr_base);

    exp_q.push_back(wr(2'd0, 32'd1, 3'd0));
    exp_q.push_back(wr(2'd1, 32'd8, 3'd4));
    exp_q.push_back(wr(2'd2, 32'd8, 3'd6));
    run_col("t6_i7", 7, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
